retire_trace_buffer: RTL and testbench
======================================

// Module: retire_trace_buffer
// PURPOSE
//  Captures every instruction word the pipeline retires, with its PC and a sequence tag, and buffers it in a FIFO.
//  Drains entries one at a time over a valid/ready handshake to the disassembly/trace stage.
//  That stage turns each 32-bit word into a MIPS text string.
//  Sits between writeback (producer) and the disassembler (consumer).
//  Decouples bursty retirement from a slow trace consumer.
// PARAMETERS
//  DEPTH       16  FIFO entries; power of two, >= 2
//  SEQ_W       16  width of sequence tag; wraps modulo 2^SEQ_W
//  FILTER_NOP  0   1 = retired words equal to 32'h0 are neither stored nor tagged
// PORTS
//  CLK         in   1        clock, all state on rising edge
//  RESET_L     in   1        asynchronous, active-low reset
//  enable      in   1        1 = capture retirements; 0 = ignore ret_valid (no tag increment)
//  flush       in   1        synchronous: empty FIFO, keep seq counter and drop stats
//  ret_valid   in   1        instruction retires this cycle
//  ret_pc      in   32       PC of retiring instruction
//  ret_inst    in   32       retiring instruction word
//  out_valid   out  1        head entry valid
//  out_ready   in   1        consumer accepts head this cycle
//  out_pc      out  32       PC of head entry
//  out_inst    out  32       instruction word of head entry (to disassembler input)
//  out_seq     out  SEQ_W    sequence tag of head entry
//  count       out  log2(DEPTH)+1  current occupancy, 0..DEPTH
//  drop_count  out  16       retirements lost to a full FIFO; saturates at 16'hFFFF
//  overflow    out  1        sticky; set on first drop, cleared only by reset
// BEHAVIOUR
//  Reset (RESET_L=0, async):
//   - out_valid=0; out_pc, out_inst, out_seq = 0.
//   - count=0, drop_count=0, overflow=0, seq counter=0, pointers=0.
//  Capture: "capture" = enable && ret_valid && !(FILTER_NOP && ret_inst==0).
//   - Each capture is tagged with the current seq value; seq then increments, even if the entry is dropped.
//   - A dropped entry therefore leaves a visible gap in out_seq.
//  Push:
//   - Capture with count<DEPTH, or with count==DEPTH while a pop occurs the same cycle, writes the entry.
//   - Otherwise the entry is dropped: drop_count+1 (saturating), overflow<=1.
//  Pop: out_valid && out_ready removes the head; the next entry is presented the following cycle.
//  Latency: head outputs are registered.
//   - A capture into an empty FIFO at edge N gives out_valid=1 after edge N+1 (1-cycle latency).
//   - No combinational path ret_* -> out_*.
//  Handshake:
//   - out_* are held stable while out_valid && !out_ready.
//   - out_valid never deasserts without a pop or a flush.
//  Simultaneous push and pop: count unchanged. In an empty FIFO, push+pop cannot occur (out_valid=0).
//  Pointers: wr/rd pointers wrap modulo DEPTH. Full vs. empty is resolved by count, not by pointer equality.
//  Flush:
//   - Takes priority over push and pop in the same cycle; the concurrent capture is discarded but still consumes a seq tag.
//   - After flush: count=0, out_valid=0 next cycle.
//  enable=0 mid-burst: entries already stored continue to drain normally.
//  Seq wrap: 2^SEQ_W-1 is followed by 0; no flag.
// STRUCTURE
//  - The NOP encoding constant (32'h0) and the default SEQ_W belong in the shared ManBearPig.h header, alongside the opcode defines.
//  - One sub-module: trace_fifo_mem, a DEPTH x (32+32+SEQ_W) register array.
//    It has a synchronous write port and an asynchronous read port, with no reset on the storage.
//  - Top level holds pointers, count, seq counter, drop stats and the output head register.
// TESTING
//  1. Reset then single retire pc=0x00400000 inst=0x20080005 -> next cycle out_valid=1, out_inst=0x20080005, out_seq=0, count=1.
//  2. out_ready=0, 16 retires, then 3 more -> count=16, drop_count=3, overflow=1; drain gives seq 0..15 in order.
//  3. FIFO full with out_ready=1 and ret_valid=1 same cycle -> no drop, count stays 16, the new entry appears last.
//  4. FILTER_NOP=1, retire 0x0, then 0x00851020 -> only the second is stored, with out_seq=0; count=1.
//  5. count=5, assert flush together with ret_valid -> count=0 and out_valid=0 next cycle; the next capture gets out_seq=6.
//  6. Drop RESET_L mid-drain with count=7 -> all outputs 0 immediately; after release, capture restarts at seq=0.

Source files
------------

// File: rtl/retire_trace_buffer_pkg.sv
// Shared constants and payload types for the retire trace buffer.
//   NOP_INST      : encoding treated as a NOP when filtering is enabled
//   SEQ_W_DEFAULT : default sequence tag width
//   ret_rec_t     : PC + instruction word of one retired instruction
package retire_trace_buffer_pkg;

    localparam logic [31:0]  NOP_INST      = 32'h0000_0000;
    localparam int unsigned  SEQ_W_DEFAULT = 16;
    localparam int unsigned  DROP_W        = 16;
    localparam int unsigned  REC_W         = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ret_rec_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Storage array for the retire trace FIFO: DEPTH x WIDTH registers,
// synchronous write, asynchronous read, no reset on the contents.
//   CLK     : write clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata_c : combinational read data
module trace_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 80
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port
    assign rdata_c = mem[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: tags each captured retirement with a sequence number,
// queues it, and presents the head through a registered valid/ready port.
//   CLK, RESET_L          : clock, async active-low reset
//   enable, flush         : capture enable, synchronous FIFO flush
//   ret_valid/pc/inst     : retirement input from writeback
//   out_valid/ready       : head handshake toward the disassembler
//   out_pc/inst/seq       : registered head entry
//   count                 : occupancy 0..DEPTH
//   drop_count, overflow  : lost-capture statistics
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned SEQ_W      = SEQ_W_DEFAULT,
    parameter bit          FILTER_NOP = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RESET_L,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   ret_valid,
    input  logic [31:0]            ret_pc,
    input  logic [31:0]            ret_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_inst,
    output logic [SEQ_W-1:0]       out_seq,
    output logic [$clog2(DEPTH):0] count,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = REC_W + SEQ_W;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SEQ_W-1:0] seq;

    logic             capture_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic [CNT_W-1:0] remain_c;
    logic [PTR_W-1:0] rd_ptr_nxt_c;
    ret_rec_t         wr_rec_c;
    ret_rec_t         rd_rec_c;
    logic [SEQ_W-1:0] rd_seq_c;
    logic [ENT_W-1:0] wdata_c;
    logic [ENT_W-1:0] rdata_c;

    // Capture / push / pop / drop decisions
    always_comb begin
        capture_c     = enable && ret_valid && !(FILTER_NOP && (ret_inst == NOP_INST));
        pop_c         = out_valid && out_ready;
        push_c        = capture_c && !flush && ((count != CNT_W'(DEPTH)) || pop_c);
        drop_c        = capture_c && !flush && !push_c;
        // Entries already resident after this cycle's pop; a same-cycle push
        // is not yet readable, which gives the one-cycle head latency.
        remain_c      = count - CNT_W'(pop_c);
        rd_ptr_nxt_c  = rd_ptr + PTR_W'(pop_c);
        wr_rec_c.pc   = ret_pc;
        wr_rec_c.inst = ret_inst;
        wdata_c       = {wr_rec_c, seq};
        rd_rec_c      = rdata_c[ENT_W-1 -: REC_W];
        rd_seq_c      = rdata_c[SEQ_W-1:0];
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .CLK     (CLK),
        .we      (push_c),
        .waddr   (wr_ptr),
        .wdata   (wdata_c),
        .raddr   (rd_ptr_nxt_c),
        .rdata_c (rdata_c)
    );

    // Sequence tag and drop statistics; flush does not touch them
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            seq        <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (capture_c) begin
                seq <= seq + SEQ_W'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
            out_seq   <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt_c;
            count  <= count + CNT_W'(push_c) - CNT_W'(pop_c);
            if (remain_c != '0) begin
                // Hold a stalled head; refill when empty or just popped
                if (!out_valid || pop_c) begin
                    out_valid <= 1'b1;
                    out_pc    <= rd_rec_c.pc;
                    out_inst  <= rd_rec_c.inst;
                    out_seq   <= rd_seq_c;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: directed retirement vectors,
// an expected-entry queue filled at stimulus time, and a monitor that pops
// and compares on every accepted head transfer.
module tb_retire_trace_buffer;

    logic        CLK;
    logic        RESET_L;
    logic        enable, flush, ret_valid, out_ready;
    logic [31:0] ret_pc, ret_inst;
    logic        out_valid;
    logic [31:0] out_pc, out_inst;
    logic [15:0] out_seq;
    logic [4:0]  count;
    logic [15:0] drop_count;
    logic        overflow;

    // Second instance with NOP filtering enabled
    logic        f_enable, f_ret_valid;
    logic [31:0] f_ret_pc, f_ret_inst;
    logic        f_out_valid;
    logic [31:0] f_out_pc, f_out_inst;
    logic [15:0] f_out_seq;
    logic [4:0]  f_count;
    logic [15:0] f_drop_count;
    logic        f_overflow;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [15:0] seq;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_seq;
    int          n_checks;
    int          n_pass;

    retire_trace_buffer #(.DEPTH(16), .SEQ_W(16), .FILTER_NOP(1'b0)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .enable(enable), .flush(flush),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_seq(out_seq), .count(count),
        .drop_count(drop_count), .overflow(overflow)
    );

    retire_trace_buffer #(.DEPTH(16), .SEQ_W(16), .FILTER_NOP(1'b1)) dut_f (
        .CLK(CLK), .RESET_L(RESET_L), .enable(f_enable), .flush(1'b0),
        .ret_valid(f_ret_valid), .ret_pc(f_ret_pc), .ret_inst(f_ret_inst),
        .out_valid(f_out_valid), .out_ready(1'b0), .out_pc(f_out_pc),
        .out_inst(f_out_inst), .out_seq(f_out_seq), .count(f_count),
        .drop_count(f_drop_count), .overflow(f_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One retirement cycle; 'stored' is the hand-derived expectation
    task automatic drive_ret(input logic [31:0] pc, input logic [31:0] inst, input bit stored);
        ret_valid = 1'b1;
        ret_pc    = pc;
        ret_inst  = inst;
        if (enable) begin
            if (stored) exp_q.push_back('{pc, inst, exp_seq});
            exp_seq = exp_seq + 16'd1;
        end
        tick();
    endtask

    task automatic idle();
        ret_valid = 1'b0;
        ret_pc    = '0;
        ret_inst  = '0;
    endtask

    task automatic do_reset();
        RESET_L = 1'b0;
        exp_q.delete();
        exp_seq = '0;
        tick();
        tick();
        RESET_L = 1'b1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (count != 0 || out_valid); i++) tick();
        out_ready = 1'b0;
        check({name, "_count"}, 80'(count), 80'(0));
        check({name, "_queue"}, 80'(exp_q.size()), 80'(0));
    endtask

    // Monitor: every accepted head transfer must match the queue front
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET_L && out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_head: got pc=0x%0h inst=0x%0h seq=%0d expected none",
                             out_pc, out_inst, out_seq);
                end else begin
                    e = exp_q.pop_front();
                    check("head", {out_pc, out_inst, out_seq}, {e.pc, e.inst, e.seq});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; exp_seq = '0;
        RESET_L = 1'b0; enable = 1'b1; flush = 1'b0; out_ready = 1'b0;
        f_enable = 1'b1; f_ret_valid = 1'b0; f_ret_pc = '0; f_ret_inst = '0;
        idle();
        do_reset();

        // Reset state
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_out_head", {out_pc, out_inst, out_seq}, 80'(0));
        check("rst_count", 80'(count), 80'(0));
        check("rst_drop_count", 80'(drop_count), 80'(0));
        check("rst_overflow", 80'(overflow), 80'(0));

        // NOP filter: 0x0 neither stored nor tagged
        f_ret_valid = 1'b1; f_ret_pc = 32'h0000_0100; f_ret_inst = 32'h0;
        tick();
        check("nop_count", 80'(f_count), 80'(0));
        f_ret_pc = 32'h0000_0104; f_ret_inst = 32'h0085_1020;
        tick();
        f_ret_valid = 1'b0;
        tick();
        check("nop_count2", 80'(f_count), 80'(1));
        check("nop_valid", 80'(f_out_valid), 80'(1));
        check("nop_head", {f_out_pc, f_out_inst, f_out_seq}, {32'h0000_0104, 32'h0085_1020, 16'd0});

        // Single retirement and head latency
        drive_ret(32'h0040_0000, 32'h2008_0005, 1'b1);
        idle();
        check("lat_valid_early", 80'(out_valid), 80'(0));
        check("lat_count", 80'(count), 80'(1));
        tick();
        check("lat_valid", 80'(out_valid), 80'(1));
        check("lat_head", {out_pc, out_inst, out_seq}, {32'h0040_0000, 32'h2008_0005, 16'd0});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_valid", 80'(out_valid), 80'(0));
        check("pop_count", 80'(count), 80'(0));

        // enable=0: ignored and untagged
        enable = 1'b0;
        drive_ret(32'h0040_0004, 32'h2009_0001, 1'b0);
        idle();
        enable = 1'b1;
        tick();
        check("disable_count", 80'(count), 80'(0));

        // Fill past full with a stalled consumer
        for (int i = 0; i < 19; i++)
            drive_ret(32'h0000_1000 + 32'(4 * i), 32'h2400_0000 + 32'(i), i < 16);
        idle();
        check("full_count", 80'(count), 80'(16));
        check("full_drops", 80'(drop_count), 80'(3));
        check("full_overflow", 80'(overflow), 80'(1));
        check("full_valid", 80'(out_valid), 80'(1));

        // Push while full and popping: accepted, count holds
        out_ready = 1'b1;
        drive_ret(32'h0000_2000, 32'h2400_00AA, 1'b1);
        out_ready = 1'b0;
        idle();
        check("fullpp_count", 80'(count), 80'(16));
        check("fullpp_drops", 80'(drop_count), 80'(3));
        drain("drain_full");
        check("sticky_overflow", 80'(overflow), 80'(1));

        // Flush with concurrent capture consumes a tag
        do_reset();
        for (int i = 0; i < 5; i++)
            drive_ret(32'h0000_3000 + 32'(4 * i), 32'h3c01_0000 + 32'(i), 1'b1);
        idle();
        tick();
        check("preflush_count", 80'(count), 80'(5));
        flush = 1'b1;
        exp_q.delete();
        drive_ret(32'h0000_3014, 32'h3c01_0005, 1'b0);
        flush = 1'b0;
        idle();
        check("flush_count", 80'(count), 80'(0));
        check("flush_valid", 80'(out_valid), 80'(0));
        drive_ret(32'h0000_3018, 32'h3c01_0006, 1'b1);
        idle();
        tick();
        check("postflush_seq", 80'(out_seq), 80'(6));
        drain("drain_flush");

        // Async reset mid-drain
        do_reset();
        for (int i = 0; i < 8; i++)
            drive_ret(32'h0000_4000 + 32'(4 * i), 32'h8c02_0000 + 32'(i), 1'b1);
        idle();
        tick();
        out_ready = 1'b1;
        tick();
        check("middrain_count", 80'(count), 80'(7));
        out_ready = 1'b0;
        RESET_L = 1'b0;
        exp_q.delete();
        exp_seq = '0;
        #1;
        check("areset_valid", 80'(out_valid), 80'(0));
        check("areset_head", {out_pc, out_inst, out_seq}, 80'(0));
        check("areset_stats", {count, drop_count, overflow}, 80'(0));
        tick();
        RESET_L = 1'b1;
        drive_ret(32'h0000_5000, 32'h2008_0007, 1'b1);
        idle();
        tick();
        check("restart_seq", 80'(out_seq), 80'(0));
        drain("drain_reset");

        check("final_queue", 80'(exp_q.size()), 80'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
